// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester round-robin arbiter in front of a single-port synchronous
//   memory. One transaction is in flight at a time. A granted request drives
//   the memory strobe for one cycle. A write then waits for mem_response,
//   and gives up after RESP_TIMEOUT cycles. A read captures mem_rdata. Each
//   transaction ends with a one-cycle ack to its requester.
//
// Ports
//   clk, reset          clock (posedge); async active-low reset
//   mN_req/wr/addr/wdata  requester N command, held until mN_ack
//   mN_ack, mN_err      one-cycle completion pulse; err = write response timeout
//   mN_rdata            last read data returned to requester N
//   mem_wr, mem_rd      memory strobes, high only during the access cycle
//   mem_addr, mem_wdata memory address/data, held through the transaction
//   mem_rdata           memory read data
//   mem_response        memory write-done flag
//   busy                high whenever a transaction is in progress
//
// state  | meaning
// IDLE   | waiting for a request; arbitration happens here
// ACCESS | memory strobe high for exactly this cycle
// W_RESP | write issued, waiting for mem_response or timeout
// R_CAP  | read issued, capture mem_rdata at the closing edge
// ACK    | ack/err visible to the winner, requests ignored
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int RESP_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_response,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, ACCESS, W_RESP, R_CAP, ACK} state_t;

  localparam int CNT_W = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(RESP_TIMEOUT - 1);

  state_t                  state, state_nxt;
  logic                    last_grant, last_grant_nxt;
  logic                    winner, winner_nxt;
  logic [CNT_W-1:0]        tmo_cnt, tmo_cnt_nxt;
  logic                    mem_wr_nxt, mem_rd_nxt;
  logic [ADDR_WIDTH-1:0]   mem_addr_nxt;
  logic [DATA_WIDTH-1:0]   mem_wdata_nxt;
  logic                    m0_ack_nxt, m0_err_nxt, m1_ack_nxt, m1_err_nxt;
  logic [DATA_WIDTH-1:0]   m0_rdata_nxt, m1_rdata_nxt;
  logic                    busy_nxt;
  logic                    pick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      winner     <= 1'b0;
      tmo_cnt    <= '0;
      mem_wr     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      m0_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_ack     <= 1'b0;
      m1_err     <= 1'b0;
      m1_rdata   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      winner     <= winner_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      mem_wr     <= mem_wr_nxt;
      mem_rd     <= mem_rd_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      m0_ack     <= m0_ack_nxt;
      m0_err     <= m0_err_nxt;
      m0_rdata   <= m0_rdata_nxt;
      m1_ack     <= m1_ack_nxt;
      m1_err     <= m1_err_nxt;
      m1_rdata   <= m1_rdata_nxt;
      busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    winner_nxt     = winner;
    tmo_cnt_nxt    = tmo_cnt;
    mem_wr_nxt     = 1'b0;
    mem_rd_nxt     = 1'b0;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    m0_ack_nxt     = 1'b0;
    m0_err_nxt     = 1'b0;
    m1_ack_nxt     = 1'b0;
    m1_err_nxt     = 1'b0;
    m0_rdata_nxt   = m0_rdata;
    m1_rdata_nxt   = m1_rdata;
    pick           = 1'b0;

    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          // A tie goes to whoever did not win the previous tie
          if (m0_req && m1_req) begin
            pick           = ~last_grant;
            last_grant_nxt = pick;
          end else begin
            pick = m1_req;
          end
          winner_nxt    = pick;
          mem_addr_nxt  = pick ? m1_addr  : m0_addr;
          mem_wdata_nxt = pick ? m1_wdata : m0_wdata;
          mem_wr_nxt    = pick ? m1_wr    : m0_wr;
          mem_rd_nxt    = pick ? ~m1_wr   : ~m0_wr;
          state_nxt     = ACCESS;
        end
      end

      ACCESS: begin
        // mem_wr still holds the direction of the access being issued
        tmo_cnt_nxt = TMO_LOAD;
        state_nxt   = mem_wr ? W_RESP : R_CAP;
      end

      W_RESP: begin
        if (mem_response || (tmo_cnt == '0)) begin
          m0_ack_nxt = ~winner;
          m1_ack_nxt = winner;
          m0_err_nxt = ~winner & ~mem_response;
          m1_err_nxt = winner & ~mem_response;
          state_nxt  = ACK;
        end else begin
          tmo_cnt_nxt = tmo_cnt - 1'b1;
        end
      end

      R_CAP: begin
        if (winner) m1_rdata_nxt = mem_rdata;
        else        m0_rdata_nxt = mem_rdata;
        m0_ack_nxt = ~winner;
        m1_ack_nxt = winner;
        state_nxt  = ACK;
      end

      ACK: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Randomized bench for mem_arbiter. A small synchronous memory sits on the
//   memory side. A transaction-level reference model predicts the outcome of
//   each transaction from the arbitration rules and the fixed latencies: who
//   wins, on which cycle the strobe and ack appear, the err flag, and the read
//   data.
module tb_mem_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RT = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_wr, m1_req, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_wr, mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_response = 1'b0;
  logic          busy;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_TIMEOUT(RT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_response(mem_response), .busy(busy)
  );

  always #5 clk = ~clk;

  // memory: write-done flag one cycle after the write strobe
  logic [DW-1:0] mem [DEPTH];
  logic          resp_en;
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    mem_response <= mem_wr & resp_en;
    mem_rdata    <= mem_rd ? mem[mem_addr] : '0;
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  int   ack_log[$];
  bit   cont;
  int   n_chk = 0;
  int   n_err = 0;

  // reference model state
  int            cyc, next_free, g, ack_e, last, t_win;
  bit            has_txn, t_wr, t_err;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, t_rdata, exp_rd0, exp_rd1;
  logic [DW-1:0] ref_mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int m, input bit wr, input int addr, input int data);
    txn_t t;
    t.wr = wr;
    t.addr = AW'(addr);
    t.wdata = DW'(data);
    if (m == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  function automatic bit pending();
    return (q0.size() > 0) || (q1.size() > 0) || m0_req || m1_req ||
           (has_txn && cyc <= ack_e + 1);
  endfunction

  task automatic run_cycle();
    bit r0, r1, a0, a1, in_t;
    int w;
    @(posedge clk);
    cyc++;
    r0 = m0_req;
    r1 = m1_req;
    if (!reset) begin
      has_txn = 0; last = 1; next_free = 0; exp_rd0 = '0; exp_rd1 = '0;
    end else if (cyc >= next_free && (r0 || r1)) begin
      w = (r0 && r1) ? (1 - last) : (r1 ? 1 : 0);
      if (r0 && r1) last = w;
      has_txn = 1; g = cyc; t_win = w;
      t_wr    = (w == 1) ? m1_wr    : m0_wr;
      t_addr  = (w == 1) ? m1_addr  : m0_addr;
      t_wdata = (w == 1) ? m1_wdata : m0_wdata;
      if (t_wr) begin
        ref_mem[t_addr] = t_wdata;
        t_err = !resp_en;
        ack_e = resp_en ? g + 2 : g + 1 + RT;
      end else begin
        t_rdata = ref_mem[t_addr];
        t_err = 0;
        ack_e = g + 2;
      end
      next_free = ack_e + 2;
    end

    @(negedge clk);
    in_t = has_txn && cyc >= g && cyc <= ack_e;
    a0 = has_txn && cyc == ack_e && t_win == 0;
    a1 = has_txn && cyc == ack_e && t_win == 1;
    if (a0 && !t_wr) exp_rd0 = t_rdata;
    if (a1 && !t_wr) exp_rd1 = t_rdata;
    chk("busy",     32'(busy),   32'(in_t));
    chk("mem_wr",   32'(mem_wr), 32'(has_txn && cyc == g && t_wr));
    chk("mem_rd",   32'(mem_rd), 32'(has_txn && cyc == g && !t_wr));
    chk("m0_ack",   32'(m0_ack), 32'(a0));
    chk("m1_ack",   32'(m1_ack), 32'(a1));
    chk("m0_err",   32'(m0_err), 32'(a0 && t_err));
    chk("m1_err",   32'(m1_err), 32'(a1 && t_err));
    chk("m0_rdata", m0_rdata, exp_rd0);
    chk("m1_rdata", m1_rdata, exp_rd1);
    if (has_txn && cyc == g) begin
      chk("mem_addr", 32'(mem_addr), 32'(t_addr));
      if (t_wr) chk("mem_wdata", mem_wdata, t_wdata);
    end
    if (m0_ack) ack_log.push_back(0);
    if (m1_ack) ack_log.push_back(1);

    // requesters: drop after ack, raise the next queued command
    if (m0_req && m0_ack) begin m0_req = 0; void'(q0.pop_front()); end
    if (m1_req && m1_ack) begin m1_req = 0; void'(q1.pop_front()); end
    if (!m0_req) begin
      if (q0.size() > 0 && (cont || $urandom_range(0, 2) == 0)) begin
        m0_req = 1; m0_wr = q0[0].wr; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
      end else begin
        m0_wr = 1'($urandom); m0_addr = AW'($urandom); m0_wdata = $urandom;
      end
    end
    if (!m1_req) begin
      if (q1.size() > 0 && (cont || $urandom_range(0, 2) == 0)) begin
        m1_req = 1; m1_wr = q1[0].wr; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
      end else begin
        m1_wr = 1'($urandom); m1_addr = AW'($urandom); m1_wdata = $urandom;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      run_cycle();
      n++;
    end
    chk("drain_pending", 32'(pending()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 0; resp_en = 1; cont = 1;
    m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0;
    cyc = 0; next_free = 0; has_txn = 0; last = 1; g = 0; ack_e = 0; t_win = 0;
    t_wr = 0; t_err = 0; t_addr = '0; t_wdata = '0; t_rdata = '0;
    exp_rd0 = '0; exp_rd1 = '0;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; ref_mem[i] = '0; end

    // reset held with random requests: everything stays at zero
    for (int i = 0; i < 6; i++) begin
      m0_req = 1'($urandom); m1_req = 1'($urandom);
      run_cycle();
      chk("rst_mem_addr",  32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
    end
    m0_req = 0; m1_req = 0;
    reset = 1;

    // both requesting after reset: M0 first, then the tie winner alternates
    ack_log.delete();
    push(0, 1, 1, 11); push(0, 1, 2, 22); push(1, 1, 9, 99);
    drain(100);
    chk("first_grant", 32'((ack_log.size() > 0) ? ack_log[0] : 2), 32'd0);

    // M0 write then read back
    cont = 0;
    push(0, 1, 3, 50); push(0, 0, 3, 0);
    drain(100);
    chk("rd_addr3", m0_rdata, 32'd50);

    // continuous requests: grants alternate, M1 sees M0's writes
    cont = 1;
    ack_log.delete();
    for (int a = 0; a < 4; a++) begin
      push(0, 1, a, $urandom);
      push(1, 0, a, 0);
    end
    drain(200);
    chk("alt_count", 32'(ack_log.size()), 32'd8);
    for (int i = 0; i < ack_log.size(); i++) chk("alt_order", 32'(ack_log[i]), 32'(i % 2));

    // write response timeout
    resp_en = 0;
    push(1, 1, 5, 32'hdead);
    drain(100);
    resp_en = 1;

    // reset in the middle of W_RESP
    resp_en = 0;
    push(0, 1, 7, 32'h77);
    n = 0;
    while (!(has_txn && cyc == g + 3) && n < 30) begin
      run_cycle();
      n++;
    end
    chk("wresp_reached", 32'(n < 30), 32'd1);
    #1 reset = 0;
    #1;
    chk("abort_mem_wr", 32'(mem_wr), 32'd0);
    chk("abort_busy",   32'(busy),   32'd0);
    chk("abort_m0_ack", 32'(m0_ack), 32'd0);
    chk("abort_m0_err", 32'(m0_err), 32'd0);
    q0.delete(); q1.delete();
    m0_req = 0; m1_req = 0;
    run_cycle();
    reset = 1;
    resp_en = 1;
    push(0, 0, 7, 0);
    drain(100);
    chk("post_rst_rd", m0_rdata, 32'h77);

    // full address range through alternating requesters
    cont = 0;
    for (int a = 0; a < DEPTH; a++) push(a % 2, 1, a, 100 + a);
    drain(400);
    for (int a = 0; a < DEPTH; a++) push(a % 2, 0, a, 0);
    drain(400);

    // random traffic, some batches without write responses
    for (int b = 0; b < 4; b++) begin
      resp_en = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 10; i++)
        push($urandom_range(0, 1), 1'($urandom), $urandom_range(0, DEPTH - 1), $urandom);
      drain(600);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
